// File: rtl/noc_link_fabric.sv
// noc_link_fabric: table-driven crossbar between router output and input staging ports, credits on reverse links.
// Latency LINK_LAT cycles, fully registered; no backpressure (credits travel on the reverse links instead).
module noc_link_fabric #(
  parameter int NUM_ROUTERS = 4,
  parameter int NUM_PORTS   = 4,
  parameter int FLIT_W      = 32,
  parameter int LINK_LAT    = 1,
  parameter int R_W         = 2,
  parameter int P_W         = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_we,
  input  logic [R_W-1:0]                            cfg_src_r,
  input  logic [P_W-1:0]                            cfg_src_p,
  input  logic [R_W-1:0]                            cfg_dst_r,
  input  logic [P_W-1:0]                            cfg_dst_p,
  input  logic                                      cfg_en,
  input  logic                                      start,
  input  logic                                      stop,
  input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]   out_staging,
  input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]   out_cr_staging,
  output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]   in_staging,
  output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]   in_cr_staging,
  output logic                                      running,
  output logic                                      conflict_err,
  output logic [31:0]                               cycle_count
);
  localparam int N     = NUM_ROUTERS * NUM_PORTS;
  localparam int BUS_W = N * FLIT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state_q;
  logic         running_q;
  logic [31:0]  cycle_count_q;
  logic [31:0]  drain_cnt_q;

  logic [N-1:0]   en_q, en_d;
  logic [R_W-1:0] dr_q [N];
  logic [R_W-1:0] dr_d [N];
  logic [P_W-1:0] dp_q [N];
  logic [P_W-1:0] dp_d [N];
  logic           conflict_err_q, conflict_err_d;

  logic [BUS_W-1:0] fl_pipe_q [LINK_LAT];
  logic [BUS_W-1:0] fl_pipe_d [LINK_LAT];
  logic [BUS_W-1:0] cr_pipe_q [LINK_LAT];
  logic [BUS_W-1:0] cr_pipe_d [LINK_LAT];

  logic         cfg_ok;
  logic         cfg_wr;
  logic [31:0]  src_idx;
  logic         conflict_now;
  logic [N-1:0] win;
  logic [BUS_W-1:0] fl_route, cr_route;

  // Table update and conflict check are both evaluated on the post-write table.
  always_comb begin
    cfg_ok  = (32'(cfg_src_r) < NUM_ROUTERS) && (32'(cfg_src_p) < NUM_PORTS) &&
              (32'(cfg_dst_r) < NUM_ROUTERS) && (32'(cfg_dst_p) < NUM_PORTS);
    cfg_wr  = cfg_we && cfg_ok && (state_q == IDLE);
    src_idx = 32'(cfg_src_r) * NUM_PORTS + 32'(cfg_src_p);
    en_d = en_q;
    dr_d = dr_q;
    dp_d = dp_q;
    for (int s = 0; s < N; s++) begin
      if (cfg_wr && (src_idx == s)) begin
        en_d[s] = cfg_en;
        dr_d[s] = cfg_dst_r;
        dp_d[s] = cfg_dst_p;
      end
    end
    conflict_now = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (en_d[i] && en_d[j] && (dr_d[i] == dr_d[j]) && (dp_d[i] == dp_d[j]))
          conflict_now = 1'b1;
      end
    end
    conflict_err_d = conflict_err_q |
                     ((state_q == IDLE) && (cfg_we || start) && conflict_now);
  end

  // A source only drives its destination if no higher-indexed enabled source shares it.
  always_comb begin
    win = en_q;
    for (int s = 0; s < N; s++) begin
      for (int j = s + 1; j < N; j++) begin
        if (en_q[j] && (dr_q[j] == dr_q[s]) && (dp_q[j] == dp_q[s]))
          win[s] = 1'b0;
      end
    end
  end

  always_comb begin
    fl_route = '0;
    cr_route = '0;
    if (state_q == RUN) begin
      for (int s = 0; s < N; s++) begin
        for (int r = 0; r < NUM_ROUTERS; r++) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (win[s] && (dr_q[s] == R_W'(r)) && (dp_q[s] == P_W'(p))) begin
              fl_route[(r*NUM_PORTS+p)*FLIT_W +: FLIT_W] = out_staging[s*FLIT_W +: FLIT_W];
              cr_route[s*FLIT_W +: FLIT_W] = out_cr_staging[(r*NUM_PORTS+p)*FLIT_W +: FLIT_W];
            end
          end
        end
      end
    end
    fl_pipe_d[0] = fl_route;
    cr_pipe_d[0] = cr_route;
    for (int k = 1; k < LINK_LAT; k++) begin
      fl_pipe_d[k] = fl_pipe_q[k-1];
      cr_pipe_d[k] = cr_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q           <= '0;
      conflict_err_q <= 1'b0;
      for (int s = 0; s < N; s++) begin
        dr_q[s] <= '0;
        dp_q[s] <= '0;
      end
      for (int k = 0; k < LINK_LAT; k++) begin
        fl_pipe_q[k] <= '0;
        cr_pipe_q[k] <= '0;
      end
    end else begin
      en_q           <= en_d;
      dr_q           <= dr_d;
      dp_q           <= dp_d;
      conflict_err_q <= conflict_err_d;
      for (int k = 0; k < LINK_LAT; k++) begin
        fl_pipe_q[k] <= fl_pipe_d[k];
        cr_pipe_q[k] <= cr_pipe_d[k];
      end
    end
  end

  // DRAIN lasts LINK_LAT cycles so the last flit sampled in RUN reaches its destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      running_q     <= 1'b0;
      cycle_count_q <= '0;
      drain_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_q + 32'd1;
          if (stop) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 32'(LINK_LAT - 1)) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_staging    = fl_pipe_q[LINK_LAT-1];
  assign in_cr_staging = cr_pipe_q[LINK_LAT-1];
  assign running       = running_q;
  assign conflict_err  = conflict_err_q;
  assign cycle_count   = cycle_count_q;
endmodule

// File: tb/tb_noc_link_fabric.sv
// Directed and randomized bench for noc_link_fabric with LINK_LAT=2 against a per-cycle reference model.
module tb_noc_link_fabric;
  localparam int NR = 4;
  localparam int NP = 4;
  localparam int FW = 32;
  localparam int LL = 2;
  localparam int N  = NR * NP;
  localparam int BW = N * FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_we, cfg_en, start, stop;
  logic [1:0]    cfg_src_r, cfg_src_p, cfg_dst_r, cfg_dst_p;
  logic [BW-1:0] out_staging, out_cr_staging;
  logic [BW-1:0] in_staging, in_cr_staging;
  logic          running, conflict_err;
  logic [31:0]   cycle_count;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 run, 2 drain
  int          m_state;
  int          m_drain_left;
  logic [31:0] m_cnt;
  bit          m_conf;
  bit          m_en [N];
  int          m_dst [N];
  logic [BW-1:0] m_fl [LL];
  logic [BW-1:0] m_cr [LL];

  noc_link_fabric #(
    .NUM_ROUTERS(NR), .NUM_PORTS(NP), .FLIT_W(FW), .LINK_LAT(LL), .R_W(2), .P_W(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_src_r(cfg_src_r), .cfg_src_p(cfg_src_p),
    .cfg_dst_r(cfg_dst_r), .cfg_dst_p(cfg_dst_p), .cfg_en(cfg_en), .start(start), .stop(stop),
    .out_staging(out_staging), .out_cr_staging(out_cr_staging),
    .in_staging(in_staging), .in_cr_staging(in_cr_staging),
    .running(running), .conflict_err(conflict_err), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input logic [BW-1:0] b, input int r, input int p);
    return b[(r*NP+p)*FW +: FW];
  endfunction

  task automatic set_fl(input int r, input int p, input logic [31:0] v);
    out_staging[(r*NP+p)*FW +: FW] = v;
  endtask

  task automatic set_cr(input int r, input int p, input logic [31:0] v);
    out_cr_staging[(r*NP+p)*FW +: FW] = v;
  endtask

  function automatic bit model_conflict();
    int hits [N];
    for (int d = 0; d < N; d++) hits[d] = 0;
    for (int s = 0; s < N; s++) if (m_en[s]) hits[m_dst[s]]++;
    for (int d = 0; d < N; d++) if (hits[d] > 1) return 1'b1;
    return 1'b0;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [BW-1:0] fl, cr;
    int win, src;
    if (rst) begin
      m_state = 0; m_drain_left = 0; m_cnt = '0; m_conf = 1'b0;
      for (int s = 0; s < N; s++) begin m_en[s] = 1'b0; m_dst[s] = 0; end
      for (int k = 0; k < LL; k++) begin m_fl[k] = '0; m_cr[k] = '0; end
      return;
    end
    fl = '0;
    cr = '0;
    if (m_state == 1) begin
      for (int d = 0; d < N; d++) begin
        win = -1;
        for (int s = N - 1; s >= 0 && win < 0; s--)
          if (m_en[s] && m_dst[s] == d) win = s;
        if (win >= 0) begin
          fl[d*FW +: FW]   = out_staging[win*FW +: FW];
          cr[win*FW +: FW] = out_cr_staging[d*FW +: FW];
        end
      end
    end
    for (int k = LL - 1; k > 0; k--) begin m_fl[k] = m_fl[k-1]; m_cr[k] = m_cr[k-1]; end
    m_fl[0] = fl;
    m_cr[0] = cr;
    case (m_state)
      0: begin
        if (cfg_we) begin
          src = int'(cfg_src_r) * NP + int'(cfg_src_p);
          m_en[src]  = cfg_en;
          m_dst[src] = int'(cfg_dst_r) * NP + int'(cfg_dst_p);
        end
        if ((cfg_we || start) && model_conflict()) m_conf = 1'b1;
        if (start) m_state = 1;
      end
      1: begin
        m_cnt = m_cnt + 1;
        if (stop) begin m_state = 2; m_drain_left = LL; end
      end
      default: begin
        m_drain_left--;
        if (m_drain_left == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic check_all();
    chk("in_staging", in_staging, m_fl[LL-1]);
    chk("in_cr_staging", in_cr_staging, m_cr[LL-1]);
    chk("running", BW'(running), BW'(m_state != 0));
    chk("conflict_err", BW'(conflict_err), BW'(m_conf));
    chk("cycle_count", BW'(cycle_count), BW'(m_cnt));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic cfg_write(input int sr, input int sp, input int dr, input int dp, input bit en);
    cfg_src_r = 2'(sr); cfg_src_p = 2'(sp);
    cfg_dst_r = 2'(dr); cfg_dst_p = 2'(dp);
    cfg_en = en; cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic clear_data();
    out_staging = '0;
    out_cr_staging = '0;
  endtask

  initial begin
    logic [BW-1:0] e;
    rst = 1'b1; cfg_we = 1'b0; cfg_en = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_src_r = '0; cfg_src_p = '0; cfg_dst_r = '0; cfg_dst_p = '0;
    clear_data();
    @(negedge clk);
    cyc();
    chk("reset_in", in_staging, '0);
    chk("reset_cr", in_cr_staging, '0);
    chk("reset_running", BW'(running), '0);
    chk("reset_count", BW'(cycle_count), '0);
    rst = 1'b0;

    // basic flit and credit path
    cfg_write(0, 1, 2, 3, 1'b1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_ignored_idle", BW'(running), '0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("run_entered", BW'(running), BW'(1));
    set_fl(0, 1, 32'h8000_00A5);
    set_cr(2, 3, 32'h8000_0001);
    cyc();
    clear_data();
    chk("lat_not_early", in_staging, '0);
    cyc();
    e = '0;
    e[(2*NP+3)*FW +: FW] = 32'h8000_00A5;
    chk("flit_0_1_to_2_3", in_staging, e);
    chk("credit_2_3_to_0_1", BW'(slot(in_cr_staging, 0, 1)), BW'(32'h8000_0001));

    // writes during RUN leave the table alone
    cfg_write(0, 1, 3, 3, 1'b1);
    set_fl(0, 1, 32'h8000_00C3);
    cyc();
    clear_data();
    cyc();
    chk("run_cfg_ignored", BW'(slot(in_staging, 2, 3)), BW'(32'h8000_00C3));
    chk("run_cfg_no_new_dst", BW'(slot(in_staging, 3, 3)), '0);

    // reset in DRAIN discards the in-flight flit
    set_fl(0, 1, 32'h8000_0077);
    stop = 1'b1; cyc(); stop = 1'b0;
    clear_data();
    chk("drain_running", BW'(running), BW'(1));
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("drain_rst_in", in_staging, '0);
    chk("drain_rst_running", BW'(running), '0);
    cyc();
    chk("drain_rst_no_partial", in_staging, '0);

    // conflicting destinations: highest source index wins
    cfg_write(0, 0, 1, 1, 1'b1);
    cfg_write(3, 2, 1, 1, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("conflict_set", BW'(conflict_err), BW'(1));
    set_fl(0, 0, 32'h8000_0011);
    set_fl(3, 2, 32'h8000_0032);
    set_cr(1, 1, 32'h8000_0005);
    cyc();
    clear_data();
    cyc();
    chk("conflict_winner_flit", BW'(slot(in_staging, 1, 1)), BW'(32'h8000_0032));
    chk("conflict_winner_cr", BW'(slot(in_cr_staging, 3, 2)), BW'(32'h8000_0005));
    chk("conflict_loser_cr", BW'(slot(in_cr_staging, 0, 0)), '0);

    // run length, drain length and last-cycle flit, with a self-loop
    rst = 1'b1; cyc(); rst = 1'b0;
    cfg_write(2, 0, 2, 0, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        stop = 1'b1;
        set_fl(2, 0, 32'h8000_BEEF);
      end
      cyc();
    end
    stop = 1'b0;
    clear_data();
    chk("count_10", BW'(cycle_count), BW'(10));
    chk("drain1_running", BW'(running), BW'(1));
    cyc();
    chk("drain2_running", BW'(running), BW'(1));
    chk("last_run_flit", BW'(slot(in_staging, 2, 0)), BW'(32'h8000_BEEF));
    cyc();
    chk("idle_after_drain", BW'(running), '0);
    chk("count_held", BW'(cycle_count), BW'(10));

    // simultaneous start and cfg_we: write lands, then RUN
    cfg_src_r = 2'd1; cfg_src_p = 2'd0; cfg_dst_r = 2'd0; cfg_dst_p = 2'd2; cfg_en = 1'b1;
    cfg_we = 1'b1; start = 1'b1;
    cyc();
    cfg_we = 1'b0; start = 1'b0;
    set_fl(1, 0, 32'h0000_1234);
    cyc();
    clear_data();
    cyc();
    chk("start_with_cfg", BW'(slot(in_staging, 0, 2)), BW'(32'h0000_1234));

    // randomized traffic and control
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_src_r = 2'($urandom_range(0, 3));
      cfg_src_p = 2'($urandom_range(0, 3));
      cfg_dst_r = 2'($urandom_range(0, 3));
      cfg_dst_p = 2'($urandom_range(0, 3));
      cfg_en    = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 11) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      for (int s = 0; s < N; s++) begin
        out_staging[s*FW +: FW]    = $urandom;
        out_cr_staging[s*FW +: FW] = $urandom;
      end
      cyc();
    end
    rst = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
